// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning logic.
package button_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int unsigned CLK_HZ = 125_000_000;

    // Convert a duration in milliseconds to system clock cycles.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first one a full cycle to resolve metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: sync, debounce, level plus press/release/long-press strobes.
// Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined;
// otherwise long_pulse is tied low and LONG_CYCLES is unused.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int unsigned LONG_CYCLES     = ms_to_cycles(1000),
    parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            btn_in;
    logic            btn_sync;
    btn_state_t      state_q;
    logic [CntW-1:0] cnt_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            press_accept;

    // Normalise polarity before synchronising so reset value 0 always means released.
    assign btn_in = BTN_ACTIVE_HIGH ? btn_raw : ~btn_raw;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (btn_in),
        .q_o    (btn_sync)
    );

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (btn_sync) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        // Release bounce: fall back without a strobe.
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_accept = (state_q == PRESS_WAIT) && btn_sync && (cnt_q == CntLast);

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned      HoldW    = $clog2(LONG_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    logic [HoldW-1:0] hold_cnt_q;
    logic             long_done_q;
    logic             long_q;

    // Hold timer runs only in PRESSED (pauses in RELEASE_WAIT) and fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (press_accept) begin
                hold_cnt_q  <= '0;
                long_done_q <= 1'b0;
            end else if ((state_q == PRESSED) && !long_done_q) begin
                if (hold_cnt_q == HoldLast) begin
                    long_q      <= 1'b1;
                    long_done_q <= 1'b1;
                end else begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_debounce;
    import button_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 10;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int checks    = 0;
    int errors    = 0;
    int n_press   = 0;
    int n_release = 0;
    int n_long    = 0;
    int n_both    = 0;

    always #4 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .BTN_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    // Strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (press_pulse) n_press++;
        if (release_pulse) n_release++;
        if (long_pulse) n_long++;
        if (press_pulse && release_pulse) n_both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_p;
        logic exp_l;
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs got %b want 0000",
                         {btn_level, press_pulse, release_pulse, long_pulse});
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_p = (e == 7);
            exp_l = (e >= 7);
            checks++;
            if (press_pulse !== exp_p || btn_level !== exp_l) begin
                errors++;
                $display("FAIL reset_exit edge %0d got press=%b level=%b want press=%b level=%b",
                         e, press_pulse, btn_level, exp_p, exp_l);
            end
        end
        btn_raw = 1'b0;
        repeat (12) tick();
        checks++;
        if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL reset_settle level got %b want 0", btn_level);
        end
    endtask

    task automatic test_clean_press();
        int   p0;
        int   r0;
        logic exp_p;
        logic exp_r;
        logic exp_l;
        p0      = n_press;
        r0      = n_release;
        btn_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_p = (e == 7);
            exp_l = (e >= 7);
            checks++;
            if (press_pulse !== exp_p || btn_level !== exp_l || release_pulse !== 1'b0) begin
                errors++;
                $display("FAIL clean_press edge %0d got press=%b level=%b rel=%b want %b %b 0",
                         e, press_pulse, btn_level, release_pulse, exp_p, exp_l);
            end
        end
        btn_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_r = (e == 7);
            exp_l = (e < 7);
            checks++;
            if (release_pulse !== exp_r || btn_level !== exp_l || press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL clean_release edge %0d got rel=%b level=%b press=%b want %b %b 0",
                         e, release_pulse, btn_level, press_pulse, exp_r, exp_l);
            end
        end
        checks++;
        if (n_press - p0 != 1 || n_release - r0 != 1) begin
            errors++;
            $display("FAIL clean_counts got press=%0d rel=%0d want 1 1",
                     n_press - p0, n_release - r0);
        end
    endtask

    task automatic test_bounce();
        int   p0;
        int   r0;
        logic exp_p;
        p0 = n_press;
        r0 = n_release;
        for (int k = 0; k < 5; k++) begin
            btn_raw = 1'b1;
            repeat (3) begin
                tick();
                checks++;
                if (btn_level !== 1'b0 || press_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_high burst %0d got level=%b press=%b want 0 0",
                             k, btn_level, press_pulse);
                end
            end
            btn_raw = 1'b0;
            repeat (2) begin
                tick();
                checks++;
                if (btn_level !== 1'b0 || press_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_low burst %0d got level=%b press=%b want 0 0",
                             k, btn_level, press_pulse);
                end
            end
        end
        checks++;
        if (n_press != p0 || n_release != r0) begin
            errors++;
            $display("FAIL bounce_strobes got press=%0d rel=%0d want 0 0",
                     n_press - p0, n_release - r0);
        end
        btn_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_p = (e == 7);
            checks++;
            if (press_pulse !== exp_p || btn_level !== exp_p) begin
                errors++;
                $display("FAIL bounce_hold edge %0d got press=%b level=%b want %b %b",
                         e, press_pulse, btn_level, exp_p, exp_p);
            end
        end
    endtask

    // Continues from the press accepted at the end of test_bounce.
    task automatic test_long();
        int   l0;
        logic exp_long;
        l0 = n_long;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp_long = LongEn && (e == 10);
            checks++;
            if (long_pulse !== exp_long || btn_level !== 1'b1 || press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL long edge %0d got long=%b level=%b press=%b want %b 1 0",
                         e, long_pulse, btn_level, press_pulse, exp_long);
            end
        end
        checks++;
        if (n_long - l0 != (LongEn ? 1 : 0)) begin
            errors++;
            $display("FAIL long_count got %0d want %0d", n_long - l0, LongEn ? 1 : 0);
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        checks++;
        if (btn_level !== 1'b0 || n_long - l0 != (LongEn ? 1 : 0)) begin
            errors++;
            $display("FAIL long_release got level=%b longs=%0d", btn_level, n_long - l0);
        end
    endtask

    task automatic test_release_bounce();
        int   r0;
        logic exp_long;
        btn_raw = 1'b1;
        repeat (7) tick();
        checks++;
        if (press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL rb_press got %b want 1", press_pulse);
        end
        r0 = n_release;
        // Two low samples at edges 4-5; hold timer pauses two cycles, long moves to edge 12.
        for (int e = 1; e <= 20; e++) begin
            if (e == 4) btn_raw = 1'b0;
            if (e == 6) btn_raw = 1'b1;
            tick();
            exp_long = LongEn && (e == 12);
            checks++;
            if (btn_level !== 1'b1 || release_pulse !== 1'b0 || long_pulse !== exp_long) begin
                errors++;
                $display("FAIL release_bounce edge %0d got level=%b rel=%b long=%b want 1 0 %b",
                         e, btn_level, release_pulse, long_pulse, exp_long);
            end
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        checks++;
        if (btn_level !== 1'b0 || n_release - r0 != 1) begin
            errors++;
            $display("FAIL rb_final got level=%b rels=%0d want 0 1", btn_level, n_release - r0);
        end
    endtask

    task automatic test_reset_mid();
        int   p0;
        int   r0;
        int   l0;
        logic exp_p;
        // Reset while qualifying a press.
        btn_raw = 1'b1;
        repeat (4) tick();
        checks++;
        if (dut.state_q !== PRESS_WAIT) begin
            errors++;
            $display("FAIL mid_qual_state got %0d want %0d", dut.state_q, PRESS_WAIT);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000
            || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL mid_qual_reset got out=%b state=%0d want 0000 %0d",
                     {btn_level, press_pulse, release_pulse, long_pulse}, dut.state_q, IDLE);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == 7);
            checks++;
            if (press_pulse !== exp_p || btn_level !== (e >= 7)) begin
                errors++;
                $display("FAIL mid_qual_exit edge %0d got press=%b level=%b want %b %b",
                         e, press_pulse, btn_level, exp_p, (e >= 7));
            end
        end
        // Reset while pressed, then come out with the button released.
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000
            || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL mid_pressed_reset got out=%b state=%0d want 0000 %0d",
                     {btn_level, press_pulse, release_pulse, long_pulse}, dut.state_q, IDLE);
        end
        p0 = n_press;
        r0 = n_release;
        l0 = n_long;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        checks++;
        if (btn_level !== 1'b0 || n_press != p0 || n_release != r0 || n_long != l0) begin
            errors++;
            $display("FAIL mid_pressed_exit got level=%b strobes=%0d/%0d/%0d want 0 0/0/0",
                     btn_level, n_press - p0, n_release - r0, n_long - l0);
        end
        checks++;
        if (n_both != 0) begin
            errors++;
            $display("FAIL press_release_overlap got %0d want 0", n_both);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long();
        test_release_bounce();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
